// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

    localparam int DW_DEF = 32;
    localparam int VW_DEF = 16;
    localparam int CNT_W  = $clog2(DW_DEF);

    // Wide enough for any DW up to 64; the top truncates to its own width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle between a requester and seq_divider.
interface seq_divider_if #(
    parameter int DW = 32,
    parameter int VW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step #(
    parameter int VW = 16
) (
    input  logic [VW:0]   r,
    input  logic          q_msb,
    input  logic [VW-1:0] d,
    output logic [VW:0]   r_next,
    output logic          q_bit
);
    logic [VW+1:0] shifted;
    logic [VW:0]   diff;

    assign shifted = {r, q_msb};
    assign diff    = shifted[VW:0] - {1'b0, d};
    assign q_bit   = (shifted >= {2'b00, d});
    assign r_next  = q_bit ? diff : shifted[VW:0];
endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, DW steps per op.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(DW);

    div_state_t    state, state_next;
    logic [DW-1:0] q_reg;
    logic [VW-1:0] d_reg;
    logic [VW:0]   r_reg;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quot_reg;
    logic [VW-1:0] rem_reg;
    logic          dbz_reg;

    logic          accept;
    logic          div0;
    logic [VW:0]   r_step;
    logic          q_bit;
    logic [DW-1:0] q_step;
    logic [DW-1:0] dividend_mag;
    logic [VW-1:0] divisor_mag;
    logic [DW-1:0] quot_final;
    logic [VW-1:0] rem_final;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;

    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [VW-1:0] neg_vw(input logic [VW-1:0] v);
        return ~v + 1'b1;
    endfunction

    // The most-negative value maps onto itself, which read unsigned is its magnitude.
    assign dividend_mag = bus.dividend[DW-1] ? neg_dw(bus.dividend) : bus.dividend;
    assign divisor_mag  = bus.divisor[VW-1]  ? neg_vw(bus.divisor)  : bus.divisor;
    assign quot_final   = neg_q ? neg_dw(q_step) : q_step;
    assign rem_final    = neg_r ? neg_vw(r_step[VW-1:0]) : r_step[VW-1:0];
`else
    assign dividend_mag = bus.dividend;
    assign divisor_mag  = bus.divisor;
    assign quot_final   = q_step;
    assign rem_final    = r_step[VW-1:0];
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign div0   = (bus.divisor == '0);

    div_step #(.VW(VW)) u_step (
        .r      (r_reg),
        .q_msb  (q_reg[DW-1]),
        .d      (d_reg),
        .r_next (r_step),
        .q_bit  (q_bit)
    );

    assign q_step = {q_reg[DW-2:0], q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = div0 ? DONE : RUN;
            RUN:  if (cnt == '0) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;

    // Result registers load either at accept (divide-by-zero) or on the final RUN step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            quot_reg <= '0;
            rem_reg  <= '0;
            dbz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= CW'(DW - 1);
                        if (div0) begin
                            quot_reg <= DW'(DIV0_QUOTIENT);
                            rem_reg  <= bus.dividend[VW-1:0];
                            dbz_reg  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        quot_reg <= quot_final;
                        rem_reg  <= rem_final;
                        dbz_reg  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Working registers need no reset: they are always loaded at accept before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            q_reg <= dividend_mag;
            d_reg <= divisor_mag;
            r_reg <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
            neg_r <= bus.dividend[DW-1];
`endif
        end else if (state == RUN) begin
            q_reg <= q_step;
            r_reg <= r_step;
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: a driver queues expected results, a monitor checks them.
module tb_seq_divider;
    import div_pkg::*;

    localparam int DW = 32;
    localparam int VW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_divider_if #(.DW(DW), .VW(VW)) bus ();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            acc;
        int            lat;
        int            hold;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares the head of the scoreboard every cycle the result is held.
    bit seen      = 1'b0;
    bit after_pop = 1'b0;
    int waitc     = 0;

    always @(negedge clk) begin
        if (after_pop) begin
            check("idle_after_handshake_in_ready", 64'(bus.in_ready), 64'd1);
            check("idle_after_handshake_out_valid", 64'(bus.out_valid), 64'd0);
            after_pop = 1'b0;
        end
        bus.out_ready = 1'b0;
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid: got out_valid=1, expected no pending result");
            end else begin
                if (!seen) begin
                    seen  = 1'b1;
                    waitc = 0;
                    check("latency", 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                end
                check("quotient", 64'(bus.quotient), 64'(sb[0].q));
                check("remainder", 64'(bus.remainder), 64'(sb[0].r));
                check("div_by_zero", 64'(bus.div_by_zero), 64'(sb[0].z));
                check("in_ready_in_done", 64'(bus.in_ready), 64'd0);
                if (waitc >= sb[0].hold) begin
                    bus.out_ready = 1'b1;
                    void'(sb.pop_front());
                    seen      = 1'b0;
                    after_pop = 1'b1;
                end else begin
                    waitc++;
                end
            end
        end
    end

    task automatic issue(input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] eq, input logic [VW-1:0] er,
                         input logic ez, input int hold, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", n);
            return;
        end
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) sb.push_back('{eq, er, ez, cyc + 1, (b == '0) ? 1 : DW + 1, hold});
        @(posedge clk);
        #1;
        // Scramble operands after accept; the result must not depend on them.
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = 16'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check({tag, "_quotient"}, 64'(bus.quotient), 64'd0);
        check({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
        check({tag, "_div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        issue(32'd15120,    16'd5,    32'd3024,       16'd0,   1'b0, 0, 1'b1);
        issue(32'd19283000, 16'd1000, 32'd19283,      16'd0,   1'b0, 0, 1'b1);
        issue(32'd3316,     16'd255,  32'd13,         16'd1,   1'b0, 0, 1'b1);
`ifndef SEQ_DIVIDER_SIGNED_EN
        issue(32'd3308805024, 16'd62468, 32'd52968,   16'd0,   1'b0, 0, 1'b1);
`endif
        issue(32'd100,      16'd0,    32'hFFFF_FFFF,  16'd100, 1'b1, 0, 1'b1);
        issue(32'd1048576,  16'd1024, 32'd1024,       16'd0,   1'b0, 10, 1'b1);
        drain();

        // Abort an operation partway through RUN.
        issue(32'd1234567, 16'd89, '0, '0, 1'b0, 0, 1'b0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_run_reset");
        rst = 1'b0;

        issue(32'd1234567, 16'd89, 32'd13871, 16'd48, 1'b0, 0, 1'b1);
`ifdef SEQ_DIVIDER_SIGNED_EN
        issue(-32'sd15120, 16'd5,   -32'sd3024, 16'd0,   1'b0, 0, 1'b1);
        issue(-32'sd7,     16'd2,   -32'sd3,    -16'sd1, 1'b0, 0, 1'b1);
        issue(32'd7,       -16'sd2, -32'sd3,    16'd1,   1'b0, 0, 1'b1);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
